// File: rtl/mult_seq_ctrl_if.sv
// Signal bundle between the multiplier-layer sequencer and its command source,
// operand buffers, adder-feedback path and downstream sink.
interface mult_seq_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    logic [LEN_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] cmd_hot_base;
    logic [ADDR_W-1:0] cmd_cold_base;
    logic              hot_rd_en;
    logic [ADDR_W-1:0] hot_rd_addr;
    logic              cold_rd_en;
    logic [ADDR_W-1:0] cold_rd_addr;
    logic              pre_valid;
    logic              sel_in;
    logic              out_stall;
    logic              mul_valid;
    logic              busy;
    logic              done;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_len, cmd_hot_base, cmd_cold_base,
        input  pre_valid, out_stall,
        output cmd_ready, hot_rd_en, hot_rd_addr, cold_rd_en, cold_rd_addr,
        output sel_in, mul_valid, busy, done
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_len, cmd_hot_base, cmd_cold_base,
        output pre_valid, out_stall,
        input  cmd_ready, hot_rd_en, hot_rd_addr, cold_rd_en, cold_rd_addr,
        input  sel_in, mul_valid, busy, done
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Multiplier-layer sequencer: streams hot/cold buffer rows (mode 0) or counts
// adder-feedback beats (mode 1) for one command, then pulses done.
module mult_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic            clk,
    input  logic            rst,
    mult_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        BUF,
        FEED,
        DRAIN,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] hot_addr_q, hot_addr_d;
    logic [ADDR_W-1:0] cold_addr_q, cold_addr_d;
    logic              mul_vld_q;

    logic rd_en;
    logic beat;
    logic cmd_ready;
    logic done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            hot_addr_q  <= '0;
            cold_addr_q <= '0;
            mul_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hot_addr_q  <= hot_addr_d;
            cold_addr_q <= cold_addr_d;
            mul_vld_q   <= rd_en;
        end
    end

    // The address registers double as the latched bases and the running read pointers.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hot_addr_d  = hot_addr_q;
        cold_addr_d = cold_addr_q;
        rd_en       = 1'b0;
        beat        = 1'b0;
        cmd_ready   = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    mode_d      = bus.cmd_mode;
                    len_d       = bus.cmd_len;
                    hot_addr_d  = bus.cmd_hot_base;
                    cold_addr_d = bus.cmd_cold_base;
                    cnt_d       = '0;
                    if (bus.cmd_len == '0) begin
                        state_d = DONE;
                    end else if (bus.cmd_mode) begin
                        state_d = FEED;
                    end else begin
                        state_d = BUF;
                    end
                end
            end
            BUF: begin
                rd_en = !bus.out_stall;
                if (rd_en) begin
                    hot_addr_d  = hot_addr_q + ADDR_W'(1);
                    cold_addr_d = cold_addr_q + ADDR_W'(1);
                    cnt_d       = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            FEED: begin
                beat = bus.pre_valid && !bus.out_stall;
                if (beat) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done;
    assign bus.hot_rd_en    = rd_en;
    assign bus.cold_rd_en   = rd_en;
    assign bus.hot_rd_addr  = hot_addr_q;
    assign bus.cold_rd_addr = cold_addr_q;
    assign bus.sel_in       = (state_q != IDLE) && mode_q;
    assign bus.mul_valid    = (state_q == FEED) ? beat : mul_vld_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: directed commands push expected
// read/mul/done events tagged with their cycle; a negedge monitor pops and compares.
module tb_mult_seq_ctrl;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   baseCyc = 0;
    int   testsRun = 0;
    int   failCount = 0;
    bit   monOn = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] hot;
        logic [7:0] cold;
    } rdExp_t;

    rdExp_t rdQ[$];
    int     mulQ[$];
    int     doneQ[$];
    rdExp_t monRd;
    int     monCyc;

    mult_seq_ctrl_if #(.ADDR_W(8), .LEN_W(9)) bus ();

    mult_seq_ctrl #(.ADDR_W(8), .LEN_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        testsRun++;
        failCount++;
        $display("[TB] FAIL %s at cycle %0d: got an event, expected none", name, cyc);
    endtask

    // Every DUT event must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (monOn) begin
            if (bus.hot_rd_en || bus.cold_rd_en) begin
                if (rdQ.size() == 0) begin
                    reportUnexpected("unexpectedRead");
                end else begin
                    monRd = rdQ.pop_front();
                    checkOutput("readCycle", cyc, monRd.cyc);
                    checkOutput("hotRdAddr", bus.hot_rd_addr, monRd.hot);
                    checkOutput("coldRdAddr", bus.cold_rd_addr, monRd.cold);
                    checkOutput("hotRdEn", bus.hot_rd_en, 1);
                    checkOutput("coldRdEn", bus.cold_rd_en, 1);
                    checkOutput("readUnderStall", bus.out_stall, 0);
                end
            end
            if (bus.mul_valid) begin
                if (mulQ.size() == 0) begin
                    reportUnexpected("unexpectedMulValid");
                end else begin
                    monCyc = mulQ.pop_front();
                    checkOutput("mulValidCycle", cyc, monCyc);
                end
            end
            if (bus.done) begin
                if (doneQ.size() == 0) begin
                    reportUnexpected("unexpectedDone");
                end else begin
                    monCyc = doneQ.pop_front();
                    checkOutput("doneCycle", cyc, monCyc);
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expRead(input int off, input logic [7:0] hot, input logic [7:0] cold);
        rdExp_t e;
        e.cyc  = baseCyc + off;
        e.hot  = hot;
        e.cold = cold;
        rdQ.push_back(e);
    endtask

    task automatic expMul(input int off);
        mulQ.push_back(baseCyc + off);
    endtask

    task automatic expDone(input int off);
        doneQ.push_back(baseCyc + off);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "CmdReady"}, bus.cmd_ready, 1);
        checkOutput({tag, "SelIn"}, bus.sel_in, 0);
        checkOutput({tag, "MulValid"}, bus.mul_valid, 0);
        checkOutput({tag, "HotRdEn"}, bus.hot_rd_en, 0);
        checkOutput({tag, "ColdRdEn"}, bus.cold_rd_en, 0);
        checkOutput({tag, "Busy"}, bus.busy, 0);
        checkOutput({tag, "Done"}, bus.done, 0);
    endtask

    // Offers a command in the current cycle (baseCyc) and returns at the start of baseCyc+1.
    task automatic applyStimulus(input logic mode, input logic [8:0] len, input logic [7:0] hot,
                                 input logic [7:0] cold, input bit checkRst);
        baseCyc           = cyc;
        bus.cmd_valid     = 1'b1;
        bus.cmd_mode      = mode;
        bus.cmd_len       = len;
        bus.cmd_hot_base  = hot;
        bus.cmd_cold_base = cold;
        @(negedge clk);
        if (checkRst) begin
            checkResetValues("afterMidReset");
        end
        checkOutput("cmdReadyAtAccept", bus.cmd_ready, 1);
        nextCycle();
        bus.cmd_valid     = 1'b0;
        bus.cmd_mode      = 1'b0;
        bus.cmd_len       = '0;
        bus.cmd_hot_base  = '0;
        bus.cmd_cold_base = '0;
    endtask

    task automatic waitDone(input string name);
        for (int k = 0; k < 40 && doneQ.size() != 0; k++) begin
            nextCycle();
        end
        if (doneQ.size() != 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL %sDoneTimeout: got no done, expected done at cycle %0d", name, doneQ[0]);
            doneQ.delete();
        end
        nextCycle();
        nextCycle();
        checkOutput({name, "ReadsLeft"}, rdQ.size(), 0);
        checkOutput({name, "MulLeft"}, mulQ.size(), 0);
        rdQ.delete();
        mulQ.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_mode      = 1'b0;
        bus.cmd_len       = '0;
        bus.cmd_hot_base  = '0;
        bus.cmd_cold_base = '0;
        bus.pre_valid     = 1'b0;
        bus.out_stall     = 1'b0;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkResetValues("reset");
        nextCycle();
        rst   = 1'b0;
        monOn = 1'b1;
        nextCycle();

        // Mode 0, len 4: back-to-back reads, mul one cycle later, done after DRAIN.
        applyStimulus(1'b0, 9'd4, 8'h10, 8'h20, 1'b0);
        expRead(1, 8'h10, 8'h20);
        expRead(2, 8'h11, 8'h21);
        expRead(3, 8'h12, 8'h22);
        expRead(4, 8'h13, 8'h23);
        expMul(2); expMul(3); expMul(4); expMul(5);
        expDone(6);
        nextCycle();
        @(negedge clk);
        checkOutput("bufSelIn", bus.sel_in, 0);
        checkOutput("bufBusy", bus.busy, 1);
        checkOutput("bufCmdReady", bus.cmd_ready, 0);
        waitDone("burst4");

        // Hot address wraps past 0xFF.
        applyStimulus(1'b0, 9'd3, 8'hFE, 8'h40, 1'b0);
        expRead(1, 8'hFE, 8'h40);
        expRead(2, 8'hFF, 8'h41);
        expRead(3, 8'h00, 8'h42);
        expMul(2); expMul(3); expMul(4);
        expDone(5);
        waitDone("wrap");

        // Two-cycle stall after the 2nd read holds off reads 3 and 4.
        applyStimulus(1'b0, 9'd4, 8'h30, 8'h50, 1'b0);
        expRead(1, 8'h30, 8'h50);
        expRead(2, 8'h31, 8'h51);
        expRead(5, 8'h32, 8'h52);
        expRead(6, 8'h33, 8'h53);
        expMul(2); expMul(3); expMul(6); expMul(7);
        expDone(8);
        nextCycle();
        nextCycle();
        bus.out_stall = 1'b1;
        nextCycle();
        nextCycle();
        bus.out_stall = 1'b0;
        waitDone("stall");

        // Mode 1, len 3: beats on relative cycles 1, 3, 4.
        applyStimulus(1'b1, 9'd3, 8'h00, 8'h00, 1'b0);
        expMul(1); expMul(3); expMul(4);
        expDone(5);
        bus.pre_valid = 1'b1;
        @(negedge clk);
        checkOutput("feedSelIn", bus.sel_in, 1);
        nextCycle();
        bus.pre_valid = 1'b0;
        @(negedge clk);
        checkOutput("feedBusy", bus.busy, 1);
        checkOutput("feedCmdReady", bus.cmd_ready, 0);
        nextCycle();
        bus.pre_valid = 1'b1;
        nextCycle();
        nextCycle();
        bus.pre_valid = 1'b0;
        waitDone("feed3");

        // Mode 1, len 2: a beat offered under stall is not consumed.
        applyStimulus(1'b1, 9'd2, 8'h00, 8'h00, 1'b0);
        expMul(2); expMul(3);
        expDone(4);
        bus.pre_valid = 1'b1;
        bus.out_stall = 1'b1;
        nextCycle();
        bus.out_stall = 1'b0;
        nextCycle();
        nextCycle();
        bus.pre_valid = 1'b0;
        waitDone("feedStall");

        // Zero-length command goes straight to DONE.
        applyStimulus(1'b1, 9'd0, 8'h77, 8'h88, 1'b0);
        expDone(1);
        @(negedge clk);
        checkOutput("len0CmdReadyInDone", bus.cmd_ready, 0);
        checkOutput("len0BusyInDone", bus.busy, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("len0CmdReadyAfter", bus.cmd_ready, 1);
        checkOutput("len0BusyAfter", bus.busy, 0);
        waitDone("len0");

        // Reset during the 2nd read of a len-8 command, then a new command at once.
        applyStimulus(1'b0, 9'd8, 8'h00, 8'h80, 1'b0);
        expRead(1, 8'h00, 8'h80);
        expRead(2, 8'h01, 8'h81);
        expMul(2);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 9'd1, 8'h05, 8'h06, 1'b1);
        expRead(1, 8'h05, 8'h06);
        expMul(2);
        expDone(3);
        waitDone("afterReset");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
